dino_game_logic: RTL and testbench



---
 rtl/dino_game_logic_if.sv | 37 +++
 rtl/dino_game_logic.sv | 231 +++++++++++++++++++++++
 tb/tb_dino_game_logic.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dino_game_logic_if.sv
// Dino game bus: frame/button inputs toward the game engine and the packed
// object list, game-over flag and score coming back out of it.
// Also owns the slot-format macros shared by the engine and its consumers.
`ifndef DINO_GAME_SLOT_DEFS
`define DINO_GAME_SLOT_DEFS
`define DATALEN 48
`define DATACOUNT 4
`define DATATYPESTART 0
`define DATAXSTART 4
`define DATAYSTART 16
`define DATAWIDTHSTART 28
`define DATAHEIGHTSTART 38
`endif

interface dino_game_logic_if;
  logic                             frame_tick;
  logic                             jump_btn;
  logic [`DATALEN*`DATACOUNT-1:0]   gamedata;
  logic                             game_over;
  logic [15:0]                      score;

  modport master (
    input  frame_tick,
    input  jump_btn,
    output gamedata,
    output game_over,
    output score
  );

  modport slave (
    output frame_tick,
    output jump_btn,
    input  gamedata,
    input  game_over,
    input  score
  );
endinterface

// File: rtl/dino_game_logic.sv
// Dinosaur runner game-state engine: jump physics, cactus scrolling/spawning,
// collision and scoring, advanced once per frame_tick. Produces the packed
// object list consumed by the VGA renderer (slot 0 = dino, then cacti).
module dino_game_logic #(
  parameter int DINO_X    = 64,
  parameter int GROUND_Y  = 332,
  parameter int DINO_W    = 44,
  parameter int DINO_H    = 48,
  parameter int CACT_W    = 24,
  parameter int CACT_H    = 48,
  parameter int JUMP_V    = 14,
  parameter int GRAVITY   = 1,
  parameter int SPEED     = 4,
  parameter int SPAWN_X   = 616,
  parameter int FIRST_GAP = 60,
  parameter int MIN_GAP   = 40
) (
  input  logic                 clock,
  input  logic                 reset,
  dino_game_logic_if.master    bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2} state_t;

  localparam int SLOT_W = `DATALEN;
  localparam int GD_W   = `DATALEN * `DATACOUNT;
  localparam logic signed [5:0]  VY_JUMP  = 6'(-JUMP_V);
  localparam logic signed [5:0]  VY_GRAV  = 6'(GRAVITY);
  localparam logic signed [11:0] GROUND_S = 12'(GROUND_Y);

  // Pack one renderer slot from its fields.
  function automatic logic [SLOT_W-1:0] pack_slot(input logic [3:0]  typ,
                                                  input logic [11:0] x,
                                                  input logic [11:0] y,
                                                  input logic [9:0]  w,
                                                  input logic [9:0]  h);
    logic [SLOT_W-1:0] s;
    s = '0;
    s[`DATATYPESTART   +: 4]  = typ;
    s[`DATAXSTART      +: 12] = x;
    s[`DATAYSTART      +: 12] = y;
    s[`DATAWIDTHSTART  +: 10] = w;
    s[`DATAHEIGHTSTART +: 10] = h;
    return s;
  endfunction

  state_t             state, state_n;
  logic [9:0]         dino_y, dino_y_n;
  logic signed [5:0]  vy, vy_n;
  // Cactus 0 is always the oldest; cactus 1 is only active if cactus 0 is.
  logic [1:0]         cact_act, cact_act_n;
  logic [1:0][9:0]    cact_x, cact_x_n;
  logic [6:0]         spawn_cnt, spawn_cnt_n;
  logic [15:0]        score, score_n;
  logic [15:0]        lfsr;
  logic               jump_prev, jump_pend, jump_edge, jump_now;
  logic               tick_run, tick_restart;
  logic [GD_W-1:0]    gamedata_r, gamedata_n;
  logic               game_over_r;
  logic [15:0]        score_r;

  // Working values of the RUN update.
  logic signed [5:0]  vy_j;
  logic signed [11:0] y_sum;
  logic [1:0]         mv_act;
  logic [1:0][9:0]    mv_x;
  logic [10:0]        right_edge;
  logic               hit;

  // A press landing in the same cycle as a tick counts for that tick.
  assign jump_edge    = bus.jump_btn & ~jump_prev;
  assign jump_now     = jump_pend | jump_edge;
  assign tick_run     = bus.frame_tick & ((state == RUN) | ((state == IDLE) & jump_now));
  assign tick_restart = bus.frame_tick & (state == OVER) & jump_now;

  // Next-state: one full game step on a RUN tick, a clean restart out of OVER.
  always_comb begin
    state_n     = state;
    dino_y_n    = dino_y;
    vy_n        = vy;
    cact_act_n  = cact_act;
    cact_x_n    = cact_x;
    spawn_cnt_n = spawn_cnt;
    score_n     = score;
    vy_j        = vy;
    y_sum       = 12'sd0;
    mv_act      = cact_act;
    mv_x        = cact_x;
    right_edge  = 11'd0;
    hit         = 1'b0;
    if (tick_run) begin
      // Jump only from standing on the ground.
      if (jump_now && (dino_y == 10'(GROUND_Y)) && (vy == 6'sd0)) begin
        vy_j = VY_JUMP;
      end else begin
        vy_j = vy;
      end
      // Physics: land when falling onto the ground, else integrate.
      y_sum = $signed({2'b00, dino_y}) + $signed({{6{vy_j[5]}}, vy_j});
      if ((y_sum >= GROUND_S) && !vy_j[5]) begin
        dino_y_n = 10'(GROUND_Y);
        vy_n     = 6'sd0;
      end else begin
        dino_y_n = y_sum[9:0];
        vy_n     = vy_j + VY_GRAV;
      end
      // Scroll cacti; one that cannot move a full step leaves the screen.
      for (int i = 0; i < 2; i++) begin
        if (cact_act[i]) begin
          if (cact_x[i] < 10'(SPEED)) begin
            mv_act[i] = 1'b0;
          end else begin
            mv_act[i] = 1'b1;
            mv_x[i]   = cact_x[i] - 10'(SPEED);
          end
        end else begin
          mv_act[i] = 1'b0;
        end
      end
      // Keep the list packed: a survivor in slot 1 moves down to slot 0.
      if (!mv_act[0] && mv_act[1]) begin
        cact_act_n  = 2'b01;
        cact_x_n[0] = mv_x[1];
        cact_x_n[1] = mv_x[1];
      end else begin
        cact_act_n = mv_act;
        cact_x_n   = mv_x;
      end
      // Spawn into the first free slot; with none free, retry next tick.
      if (spawn_cnt == 7'd0) begin
        if (!cact_act_n[0]) begin
          cact_act_n[0] = 1'b1;
          cact_x_n[0]   = 10'(SPAWN_X);
          spawn_cnt_n   = 7'(MIN_GAP) + {1'b0, lfsr[5:0]};
        end else if (!cact_act_n[1]) begin
          cact_act_n[1] = 1'b1;
          cact_x_n[1]   = 10'(SPAWN_X);
          spawn_cnt_n   = 7'(MIN_GAP) + {1'b0, lfsr[5:0]};
        end else begin
          spawn_cnt_n = 7'd0;
        end
      end else begin
        spawn_cnt_n = spawn_cnt - 7'd1;
      end
      // Strict box overlap between the updated dino and each live cactus.
      for (int i = 0; i < 2; i++) begin
        right_edge = {1'b0, cact_x_n[i]} + 11'(CACT_W);
        if (cact_act_n[i] && (cact_x_n[i] < 10'(DINO_X + DINO_W)) &&
            (right_edge > 11'(DINO_X)) &&
            ((11'(dino_y_n) + 11'(DINO_H)) > 11'(GROUND_Y)) &&
            (dino_y_n < 10'(GROUND_Y + CACT_H))) begin
          hit = 1'b1;
        end else begin
          hit = hit;
        end
      end
      state_n = hit ? OVER : RUN;
      score_n = (score == 16'hFFFF) ? score : score + 16'd1;
    end else if (tick_restart) begin
      state_n     = RUN;
      dino_y_n    = 10'(GROUND_Y);
      vy_n        = 6'sd0;
      cact_act_n  = 2'b00;
      spawn_cnt_n = 7'(FIRST_GAP);
      score_n     = 16'd0;
    end else begin
      state_n = state;
    end
  end

  // Object list built from the next state so it lands together with it.
  always_comb begin
    gamedata_n = '0;
    gamedata_n[0 +: SLOT_W] = pack_slot(4'd1, 12'(DINO_X), {2'b00, dino_y_n},
                                        10'(DINO_W), 10'(DINO_H));
    for (int i = 0; i < 2; i++) begin
      if (cact_act_n[i]) begin
        gamedata_n[(i+1)*SLOT_W +: SLOT_W] = pack_slot(4'd2, {2'b00, cact_x_n[i]},
                                                       12'(GROUND_Y), 10'(CACT_W),
                                                       10'(CACT_H));
      end else begin
        gamedata_n[(i+1)*SLOT_W +: SLOT_W] = '0;
      end
    end
  end

  // Game state, button edge tracking, LFSR and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      dino_y      <= 10'(GROUND_Y);
      vy          <= 6'sd0;
      cact_act    <= 2'b00;
      cact_x      <= '0;
      spawn_cnt   <= 7'(FIRST_GAP);
      score       <= 16'd0;
      lfsr        <= 16'hACE1;
      jump_prev   <= 1'b0;
      jump_pend   <= 1'b0;
      gamedata_r  <= {{(GD_W-SLOT_W){1'b0}},
                      pack_slot(4'd1, 12'(DINO_X), 12'(GROUND_Y), 10'(DINO_W), 10'(DINO_H))};
      game_over_r <= 1'b0;
      score_r     <= 16'd0;
    end else begin
      state     <= state_n;
      dino_y    <= dino_y_n;
      vy        <= vy_n;
      cact_act  <= cact_act_n;
      cact_x    <= cact_x_n;
      spawn_cnt <= spawn_cnt_n;
      score     <= score_n;
      lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      jump_prev <= bus.jump_btn;
      if (bus.frame_tick) begin
        jump_pend <= 1'b0;
      end else if (jump_edge) begin
        jump_pend <= 1'b1;
      end else begin
        jump_pend <= jump_pend;
      end
      gamedata_r  <= gamedata_n;
      game_over_r <= (state_n == OVER);
      score_r     <= score_n;
    end
  end

  assign bus.gamedata  = gamedata_r;
  assign bus.game_over = game_over_r;
  assign bus.score     = score_r;

endmodule

// File: tb/tb_dino_game_logic.sv
// Bench for dino_game_logic: a queue-based game model run alongside the DUT,
// randomized tick spacing and presses, plus hand-computed anchor values.
`ifndef DINO_GAME_SLOT_DEFS
`define DINO_GAME_SLOT_DEFS
`define DATALEN 48
`define DATACOUNT 4
`define DATATYPESTART 0
`define DATAXSTART 4
`define DATAYSTART 16
`define DATAWIDTHSTART 28
`define DATAHEIGHTSTART 38
`endif

module tb_dino_game_logic;
  localparam int GY = 332;

  logic clock = 1'b0;
  logic reset;
  dino_game_logic_if bus();

  dino_game_logic dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  // Model state: 0 idle, 1 run, 2 over; cacti kept oldest-first in a queue.
  int m_state, m_y, m_vy, m_cnt, m_score, m_lfsr;
  int m_q[$];
  bit m_pend, m_prev;
  bit autopilot, rnd_press;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] mk_slot(input int t, input int x, input int y,
                                          input int w, input int h);
    logic [47:0] s;
    s = '0;
    s[`DATATYPESTART   +: 4]  = 4'(t);
    s[`DATAXSTART      +: 12] = 12'(x);
    s[`DATAYSTART      +: 12] = 12'(y);
    s[`DATAWIDTHSTART  +: 10] = 10'(w);
    s[`DATAHEIGHTSTART +: 10] = 10'(h);
    return s;
  endfunction

  function automatic logic [191:0] exp_gd();
    logic [191:0] g;
    g = '0;
    g[0 +: 48] = mk_slot(1, 64, m_y, 44, 48);
    foreach (m_q[i]) g[(i+1)*48 +: 48] = mk_slot(2, m_q[i], GY, 24, 48);
    return g;
  endfunction

  function automatic int get_field(input int slot, input int off, input int w);
    logic [191:0] g;
    int v;
    g = bus.gamedata;
    v = 0;
    for (int b = 0; b < w; b++) v[b] = g[slot*48 + off + b];
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_y = GY; m_vy = 0; m_cnt = 60; m_score = 0;
    m_lfsr = 16'hACE1; m_pend = 0; m_prev = 0;
    m_q = {};
  endtask

  // One clock of the game rules.
  task automatic model_clock(input bit tick, input bit btn);
    bit edge_s, pend, hit;
    int nq[$];
    edge_s = btn && !m_prev;
    pend = m_pend || edge_s;
    if (tick) begin
      if (m_state == 1 || (m_state == 0 && pend)) begin
        if (pend && m_y == GY && m_vy == 0) m_vy = -14;
        if (m_y + m_vy >= GY && m_vy >= 0) begin m_y = GY; m_vy = 0; end
        else begin m_y = m_y + m_vy; m_vy = m_vy + 1; end
        nq = {};
        foreach (m_q[i]) if (m_q[i] >= 4) nq.push_back(m_q[i] - 4);
        m_q = nq;
        if (m_cnt == 0) begin
          if (m_q.size() < 2) begin m_q.push_back(616); m_cnt = 40 + (m_lfsr & 63); end
        end else m_cnt--;
        hit = 0;
        foreach (m_q[i])
          if (m_q[i] < 108 && m_q[i] + 24 > 64 && GY < m_y + 48 && m_y < GY + 48) hit = 1;
        m_state = hit ? 2 : 1;
        if (m_score < 65535) m_score++;
      end else if (m_state == 2 && pend) begin
        m_state = 1; m_y = GY; m_vy = 0; m_q = {}; m_cnt = 60; m_score = 0;
      end
      m_pend = 0;
    end else if (edge_s) m_pend = 1;
    m_prev = btn;
    m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1)) & 16'hFFFF;
  endtask

  task automatic compare_all();
    bit packed_ok;
    packed_ok = 1;
    for (int s = 1; s < 4; s++)
      if (get_field(s, `DATATYPESTART, 4) != 0 && get_field(s-1, `DATATYPESTART, 4) == 0) packed_ok = 0;
    check("gamedata", bus.gamedata, exp_gd());
    check("game_over", 192'(bus.game_over), 192'(m_state == 2));
    check("score", 192'(bus.score), 192'(m_score));
    check("contiguous", 192'(packed_ok), 192'(1));
  endtask

  task automatic step(input bit tick, input bit btn);
    bus.frame_tick = tick;
    bus.jump_btn   = btn;
    model_clock(tick, btn);
    @(posedge clock); #1;
    compare_all();
  endtask

  task automatic press();
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
  endtask

  function automatic bit need_jump();
    bit r;
    r = 0;
    if (m_state == 1 && m_y == GY && m_vy == 0)
      foreach (m_q[i]) if (m_q[i] - 4 >= 120 && m_q[i] - 4 <= 136) r = 1;
    return r;
  endfunction

  task automatic do_tick();
    int gap;
    gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++) step(1'b0, 1'b0);
    if (autopilot && need_jump()) press();
    step(1'b1, rnd_press && ($urandom_range(0, 15) == 0));
  endtask

  task automatic apply_reset();
    bus.frame_tick = 1'b0;
    bus.jump_btn   = 1'b0;
    reset = 1'b1;
    model_reset();
    @(posedge clock); #1;
    compare_all();
    reset = 1'b0;
  endtask

  initial begin
    logic [191:0] dino_only, gsave;
    int s0;
    bit found;
    dino_only = '0;
    dino_only[0 +: 48] = mk_slot(1, 64, GY, 44, 48);
    autopilot = 0; rnd_press = 0;
    bus.frame_tick = 1'b0; bus.jump_btn = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("reset_gamedata", bus.gamedata, dino_only);
    compare_all();
    reset = 1'b0;

    // Idle ticks without a press leave the dino standing.
    repeat (5) do_tick();
    check("idle_type0", 192'(get_field(0, `DATATYPESTART, 4)), 192'(1));
    check("idle_x0", 192'(get_field(0, `DATAXSTART, 12)), 192'(64));
    check("idle_y0", 192'(get_field(0, `DATAYSTART, 12)), 192'(332));
    check("idle_w0", 192'(get_field(0, `DATAWIDTHSTART, 10)), 192'(44));
    check("idle_h0", 192'(get_field(0, `DATAHEIGHTSTART, 10)), 192'(48));
    check("idle_type1", 192'(get_field(1, `DATATYPESTART, 4)), 192'(0));
    check("idle_score", 192'(bus.score), 192'(0));

    // Start with a jump, then run through the first cactus lifetime.
    press();
    for (int t = 1; t <= 216; t++) begin
      if (t == 30) autopilot = 1;
      do_tick();
      case (t)
        1:   check("jump_t1_y", 192'(get_field(0, `DATAYSTART, 12)), 192'(318));
        14:  check("jump_peak_y", 192'(get_field(0, `DATAYSTART, 12)), 192'(227));
        29:  check("jump_land_y", 192'(get_field(0, `DATAYSTART, 12)), 192'(332));
        30:  check("jump_rest_y", 192'(get_field(0, `DATAYSTART, 12)), 192'(332));
        61: begin
          check("spawn_type", 192'(get_field(1, `DATATYPESTART, 4)), 192'(2));
          check("spawn_x", 192'(get_field(1, `DATAXSTART, 12)), 192'(616));
        end
        62:  check("scroll_x", 192'(get_field(1, `DATAXSTART, 12)), 192'(612));
        215: check("edge_x", 192'(get_field(1, `DATAXSTART, 12)), 192'(0));
        216: begin
          check("expired", 192'(get_field(1, `DATAXSTART, 12) != 0 ||
                                 get_field(1, `DATATYPESTART, 4) == 0), 192'(1));
          check("alive", 192'(bus.game_over), 192'(0));
        end
        default: ;
      endcase
      if (t == 10) press();
    end

    // Stop dodging: the next cactus must end the game.
    autopilot = 0;
    found = 0;
    for (int k = 0; k < 400 && !found; k++) begin
      do_tick();
      if (m_state == 2) found = 1;
    end
    if (!found) begin
      n_checks++; n_errors++;
      $display("FAIL reach_over: got no game over expected game over within 400 ticks");
    end
    check("over_flag", 192'(bus.game_over), 192'(1));
    s0 = m_score;
    gsave = exp_gd();
    repeat (8) do_tick();
    check("frozen_score", 192'(bus.score), 192'(s0));
    check("frozen_gd", bus.gamedata, gsave);
    press();
    do_tick();
    check("restart_score", 192'(bus.score), 192'(0));
    check("restart_over", 192'(bus.game_over), 192'(0));
    check("restart_type1", 192'(get_field(1, `DATATYPESTART, 4)), 192'(0));
    check("restart_y", 192'(get_field(0, `DATAYSTART, 12)), 192'(332));

    // Random play with occasional presses, including on tick cycles.
    autopilot = 1; rnd_press = 1;
    repeat (700) do_tick();
    autopilot = 0; rnd_press = 0;

    // Reset in the middle of a jump.
    apply_reset();
    press();
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      do_tick();
      if (m_y < 260) found = 1;
    end
    if (!found) begin
      n_checks++; n_errors++;
      $display("FAIL midair: got grounded dino expected dino_y below 260");
    end
    reset = 1'b1;
    #2;
    check("async_rst_gd", bus.gamedata, dino_only);
    check("async_rst_score", 192'(bus.score), 192'(0));
    check("async_rst_over", 192'(bus.game_over), 192'(0));
    model_reset();
    @(posedge clock); #1;
    compare_all();
    reset = 1'b0;
    repeat (5) do_tick();
    check("post_rst_y", 192'(get_field(0, `DATAYSTART, 12)), 192'(332));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
